key_clock_control: RTL and testbench

Input-conditioning and core-clocking stage that sits directly downstream of the board's push-buttons and slide switches inside `fpga_top`, and upstream of the RISC-V core. It synchronizes `KEY`/`SW`, debounces the active-low keys, and produces press/release pulses. From those it generates the core reset and a core clock-enable with three behaviours: free-run at a switch-selected rate, halt, and single-step.

---
 rtl/key_clock_control.sv | 134 +++++++++++++
 tb/tb_key_clock_control.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/key_clock_control.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module  : key_clock_control
// Purpose : Synchronizes and debounces board keys/switches, stretches the
//           core reset and generates the core clock-enable (run/halt/step).
// Rev     : 1.0  initial release
// ---------------------------------------------------------------------------
module key_clock_control #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int RESET_STRETCH   = 16
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] key_n,
  input  logic [9:0] switch,
  output logic [9:0] switch_sync,
  output logic [3:0] key_level,
  output logic [3:0] key_press,
  output logic [3:0] key_release,
  output logic       core_reset,
  output logic       core_clock_enable,
  output logic       run_mode
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam int RW = $clog2(RESET_STRETCH + 1);
  localparam logic [CW-1:0] DB_LAST      = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [RW-1:0] STRETCH_LOAD = RW'(RESET_STRETCH);

  typedef enum logic {
    HALT = 1'b0,
    RUN  = 1'b1
  } mode_t;

  logic [3:0]    key_meta;
  logic [3:0]    key_sync;
  logic [9:0]    switch_meta;
  logic [CW-1:0] db_count [4];
  logic [RW-1:0] stretch;
  logic [RW-1:0] stretch_next;
  mode_t         mode;
  logic [14:0]   div_count;
  logic [15:0]   terminal;
  logic          div_pulse;
  logic          step_req;

  // Two-flop synchronizers; keys idle released (high), switches idle low
  always_ff @(posedge clock) begin
    if (reset) begin
      key_meta    <= '1;
      key_sync    <= '1;
      switch_meta <= '0;
      switch_sync <= '0;
    end else begin
      key_meta    <= key_n;
      key_sync    <= key_meta;
      switch_meta <= switch;
      switch_sync <= switch_meta;
    end
  end

  // Per-key debounce: accept a change only after DEBOUNCE_CYCLES differing samples
  always_ff @(posedge clock) begin
    if (reset) begin
      key_level   <= '0;
      key_press   <= '0;
      key_release <= '0;
      for (int i = 0; i < 4; i++) db_count[i] <= '0;
    end else begin
      key_press   <= '0;
      key_release <= '0;
      for (int i = 0; i < 4; i++) begin
        // key_sync is active-low, so key_sync != level means pressed == level
        if (key_sync[i] != key_level[i]) begin
          db_count[i] <= '0;
        end else if (db_count[i] == DB_LAST) begin
          db_count[i]    <= '0;
          key_level[i]   <= ~key_level[i];
          key_press[i]   <= ~key_level[i];
          key_release[i] <= key_level[i];
        end else begin
          db_count[i] <= db_count[i] + 1'b1;
        end
      end
    end
  end

  // Next stretch count: reload while reset or key 0 held, else count down
  always_comb begin
    stretch_next = stretch;
    if (reset || key_level[0]) begin
      stretch_next = STRETCH_LOAD;
    end else if (stretch != '0) begin
      stretch_next = stretch - 1'b1;
    end
  end

  // Stretch counter and registered core reset
  always_ff @(posedge clock) begin
    stretch    <= stretch_next;
    core_reset <= (stretch_next != '0);
  end

  // Divider terminal, run pulse and halt-mode step request
  always_comb begin
    terminal  = (16'd1 << switch_sync[3:0]) - 16'd1;
    div_pulse = (mode == RUN) && ({1'b0, div_count} >= terminal);
    step_req  = (mode == HALT) && key_press[2] && !key_press[1];
  end

  // Mode FSM, rate divider and registered clock enable
  always_ff @(posedge clock) begin
    if (reset) begin
      mode              <= HALT;
      run_mode          <= 1'b0;
      div_count         <= '0;
      core_clock_enable <= 1'b1;
    end else begin
      // Enable tracks the core reset so the core's synchronous reset is seen
      core_clock_enable <= (stretch_next != '0) || div_pulse || step_req;
      if (key_press[1]) begin
        mode      <= (mode == HALT) ? RUN : HALT;
        run_mode  <= (mode == HALT);
        div_count <= '0;
      end else if ((mode == RUN) && !div_pulse) begin
        div_count <= div_count + 15'd1;
      end else begin
        div_count <= '0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_key_clock_control.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module  : tb_key_clock_control
// Purpose : Directed + randomized bench against a behavioural reference model
// Rev     : 1.0  initial release
// ---------------------------------------------------------------------------
module tb_key_clock_control;

  localparam int DEB = 4;
  localparam int RS  = 4;

  logic       clock = 1'b0;
  logic       reset;
  logic [3:0] key_n;
  logic [9:0] switch;
  logic [9:0] switch_sync;
  logic [3:0] key_level;
  logic [3:0] key_press;
  logic [3:0] key_release;
  logic       core_reset;
  logic       core_clock_enable;
  logic       run_mode;

  always #5 clock = ~clock;

  key_clock_control #(
    .DEBOUNCE_CYCLES(DEB),
    .RESET_STRETCH  (RS)
  ) dut (
    .clock            (clock),
    .reset            (reset),
    .key_n            (key_n),
    .switch           (switch),
    .switch_sync      (switch_sync),
    .key_level        (key_level),
    .key_press        (key_press),
    .key_release      (key_release),
    .core_reset       (core_reset),
    .core_clock_enable(core_clock_enable),
    .run_mode         (run_mode)
  );

  int vectors     = 0;
  int miscompares = 0;

  // observation counters for directed scenarios
  int obs_en = 0;
  int obs_crst = 0;
  int obs_p0 = 0;
  int obs_r0 = 0;

  // reference model state (value after the most recent edge)
  logic [3:0] m_k1, m_k2, m_lvl, m_prs, m_rel;
  logic [9:0] m_s1, m_s2;
  int         m_cnt [4];
  int         m_rs;
  bit         m_run;
  int         m_since;
  bit         m_crst, m_en;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // One clock edge of the specified behaviour, given the inputs seen at that edge
  task automatic model_step(input logic r, input logic [3:0] k, input logic [9:0] s);
    logic [3:0] o_k1, o_k2, o_lvl, o_prs;
    logic [9:0] o_s1, o_s2;
    bit         o_run, pulse, step, toggle;
    int         limit;
    o_k1 = m_k1; o_k2 = m_k2; o_lvl = m_lvl; o_prs = m_prs;
    o_s1 = m_s1; o_s2 = m_s2; o_run = m_run;
    if (r) begin
      m_k1 = 4'hF; m_k2 = 4'hF; m_s1 = '0; m_s2 = '0;
      m_lvl = '0; m_prs = '0; m_rel = '0;
      for (int i = 0; i < 4; i++) m_cnt[i] = 0;
      m_rs = RS; m_run = 0; m_since = 0; m_crst = 1; m_en = 1;
      return;
    end
    m_k1 = k; m_k2 = o_k1; m_s1 = s; m_s2 = o_s1;
    // count consecutive disagreeing samples; the DEB-th one flips the level
    m_lvl = o_lvl;
    for (int i = 0; i < 4; i++) begin
      if ((!o_k2[i]) == o_lvl[i]) m_cnt[i] = 0;
      else begin
        m_cnt[i]++;
        if (m_cnt[i] == DEB) begin
          m_lvl[i] = ~o_lvl[i];
          m_cnt[i] = 0;
        end
      end
    end
    m_prs = m_lvl & ~o_lvl;
    m_rel = ~m_lvl & o_lvl;
    if (o_lvl[0]) m_rs = RS;
    else if (m_rs > 0) m_rs--;
    m_crst = (m_rs > 0);
    toggle = o_prs[1];
    step   = !o_run && o_prs[2] && !o_prs[1];
    pulse  = 0;
    if (o_run) begin
      limit = (1 << o_s2[3:0]) - 1;
      if (m_since >= limit) begin pulse = 1; m_since = 0; end
      else m_since++;
    end else m_since = 0;
    if (toggle) begin
      m_run   = !o_run;
      m_since = 0;
    end
    m_en = m_crst || pulse || step;
  endtask

  task automatic compare_all();
    check("switch_sync", 32'(switch_sync), 32'(m_s2));
    check("key_level", 32'(key_level), 32'(m_lvl));
    check("key_press", 32'(key_press), 32'(m_prs));
    check("key_release", 32'(key_release), 32'(m_rel));
    check("core_reset", 32'(core_reset), 32'(m_crst));
    check("core_clock_enable", 32'(core_clock_enable), 32'(m_en));
    check("run_mode", 32'(run_mode), 32'(m_run));
    obs_en   = obs_en + int'(core_clock_enable);
    obs_crst = obs_crst + int'(core_reset);
    obs_p0   = obs_p0 + int'(key_press[0]);
    obs_r0   = obs_r0 + int'(key_release[0]);
  endtask

  // Drive inputs (called at a falling edge), clock once, update model, compare
  task automatic tick(input logic r, input logic [3:0] k, input logic [9:0] s);
    reset = r; key_n = k; switch = s;
    @(posedge clock);
    model_step(r, k, s);
    @(negedge clock);
    compare_all();
  endtask

  task automatic ticks(input int n, input logic [3:0] k, input logic [9:0] s);
    for (int i = 0; i < n; i++) tick(1'b0, k, s);
  endtask

  task automatic clear_obs();
    obs_en = 0; obs_crst = 0; obs_p0 = 0; obs_r0 = 0;
  endtask

  int         hold [4];
  bit         down [4];
  logic [3:0] rkn;
  logic [9:0] rsw;
  int         waited;

  initial begin
    reset = 1'b1; key_n = 4'hF; switch = '0;

    // reset release: core_reset high for the last reset cycle plus RS-1 more
    tick(1'b1, 4'hF, '0);
    tick(1'b1, 4'hF, '0);
    clear_obs();
    tick(1'b1, 4'hF, '0);
    ticks(6, 4'hF, '0);
    check("reset_stretch_cycles", 32'(obs_crst), 32'(RS));
    check("reset_run_mode", 32'(run_mode), 32'd0);

    // glitch shorter than the debounce window is rejected
    clear_obs();
    ticks(3, 4'hE, '0);
    ticks(10, 4'hF, '0);
    check("glitch_no_press", 32'(obs_p0), 32'd0);
    check("glitch_no_reset", 32'(obs_crst), 32'd0);

    // stable key 0 press: one press pulse, reset held, one release pulse
    clear_obs();
    ticks(10, 4'hE, '0);
    check("stable_press_once", 32'(obs_p0), 32'd1);
    ticks(20, 4'hF, '0);
    check("release_once", 32'(obs_r0), 32'd1);
    check("reset_dropped", 32'(core_reset), 32'd0);

    // single step twice in HALT
    for (int n = 0; n < 2; n++) begin
      clear_obs();
      ticks(10, 4'hB, '0);
      ticks(12, 4'hF, '0);
      check("step_pulse_count", 32'(obs_en), 32'd1);
    end

    // run at rate 8: first pulse 256 cycles after entry, then every 256
    ticks(4, 4'hF, 10'b0000001000);
    waited = 0;
    while (!run_mode && waited < 20) begin
      tick(1'b0, 4'hD, 10'b0000001000);
      waited++;
    end
    check("run_entry", 32'(run_mode), 32'd1);
    clear_obs();
    ticks(520, 4'hF, 10'b0000001000);
    check("run_pulses_256", 32'(obs_en), 32'd2);
    ticks(90, 4'hF, 10'b0000001000);

    // rate drop below current count gives a prompt pulse
    clear_obs();
    ticks(3, 4'hF, 10'b0000000010);
    check("rate_drop_pulse", 32'(obs_en != 0), 32'd1);
    ticks(20, 4'hF, 10'b0000000010);

    // back to HALT, pulses stop
    ticks(10, 4'hD, 10'b0000000010);
    ticks(10, 4'hF, 10'b0000000010);
    clear_obs();
    ticks(20, 4'hF, 10'b0000000010);
    check("halt_no_pulses", 32'(obs_en), 32'd0);

    // simultaneous keys 1 and 2 in HALT: toggle wins
    ticks(10, 4'h9, 10'b0000000010);
    ticks(10, 4'hF, 10'b0000000010);
    check("simul_enters_run", 32'(run_mode), 32'd1);
    ticks(10, 4'hD, 10'b0000000010);
    ticks(10, 4'hF, 10'b0000000010);

    // reset in the middle of a debounce count
    ticks(3, 4'hE, '0);
    tick(1'b1, 4'hE, '0);
    ticks(12, 4'hF, '0);

    // randomized phase
    for (int i = 0; i < 4; i++) begin hold[i] = 0; down[i] = 0; end
    rsw = '0;
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < 4; i++) begin
        if (hold[i] == 0) begin
          down[i] = ($urandom_range(0, (i == 0) ? 5 : 2) == 0);
          hold[i] = down[i] ? $urandom_range(1, 12) : $urandom_range(1, 25);
        end else hold[i]--;
        rkn[i] = ~down[i];
      end
      if ($urandom_range(0, 39) == 0) begin
        rsw = 10'($urandom);
        rsw[3:0] = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15))
                                                 : 4'($urandom_range(0, 3));
      end
      tick(($urandom_range(0, 399) == 0), rkn, rsw);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
